threshold_detector_seq: RTL

THRESHOLD_DETECTOR_SEQ -- requirements
Module: threshold_detector_seq

---
 rtl/threshold_detector_seq_pkg.sv | 28 ++
 rtl/threshold_detector_seq_if.sv | 26 ++
 rtl/popcount_n.sv | 18 +
 rtl/threshold_detector_seq.sv | 132 +++++++++++++
 4 files changed

// File: rtl/threshold_detector_seq_pkg.sv
// Shared definitions for the threshold detector: FSM state encoding,
// mode constants and the sample qualification rule.
package threshold_detector_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMING   = 2'd1,
        ST_DETECTED = 2'd2
    } state_e;

    localparam logic MODE_AT_LEAST = 1'b0;
    localparam logic MODE_EXACTLY  = 1'b1;

    // A sample qualifies when its ones-count meets the threshold rule
    // selected by mode (at-least-K or exactly-K).
    function automatic logic qualifies(input int unsigned ones,
                                       input int unsigned k,
                                       input logic        mode);
        logic q;
        if (mode == MODE_EXACTLY) begin
            q = (ones == k);
        end else begin
            q = (ones >= k);
        end
        return q;
    endfunction

endpackage

// File: rtl/threshold_detector_seq_if.sv
// Sample-in / detect-out bundle of the threshold detector.
interface threshold_detector_seq_if #(
    parameter int N  = 3,
    parameter int CW = 8
);
    localparam int PW = $clog2(N + 1);

    logic          in_val;
    logic [N-1:0]  in;
    logic          mode;
    logic          clear;
    logic          out;
    logic [PW-1:0] popcount;
    logic          sticky;
    logic [CW-1:0] event_count;

    modport master (
        output in_val, in, mode, clear,
        input  out, popcount, sticky, event_count
    );

    modport slave (
        input  in_val, in, mode, clear,
        output out, popcount, sticky, event_count
    );
endinterface

// File: rtl/popcount_n.sv
// Parametrised combinational ones-counter.
module popcount_n #(
    parameter int N  = 3,
    parameter int PW = $clog2(N + 1)
) (
    input  logic [N-1:0]  bits,
    output logic [PW-1:0] ones
);

    // Sum the set bits of the input word.
    always_comb begin
        ones = {PW{1'b0}};
        for (int i = 0; i < N; i++) begin
            ones = ones + PW'(bits[i]);
        end
    end

endmodule

// File: rtl/threshold_detector_seq.sv
// Threshold detector: raises out once HOLD consecutive accepted samples
// qualify (ones-count at-least-K or exactly-K), and keeps a sticky flag and
// a saturating count of detect events. All outputs come straight from flops.
module threshold_detector_seq
    import threshold_detector_seq_pkg::*;
#(
    parameter int N    = 3,
    parameter int K    = 2,
    parameter int HOLD = 1,
    parameter int CW   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    threshold_detector_seq_if.slave  bus
);

    localparam int            PW      = $clog2(N + 1);
    localparam logic [7:0]    HOLD_V  = 8'(HOLD);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_e        state_r;
    logic [7:0]    hold_cnt_r;
    logic          out_r;
    logic [PW-1:0] popcount_r;
    logic          sticky_r;
    logic [CW-1:0] event_cnt_r;

    logic [PW-1:0] ones_s;
    logic          qual_s;
    logic          enter_det_s;

    popcount_n #(.N(N), .PW(PW)) u_popcount (
        .bits (bus.in),
        .ones (ones_s)
    );

    // Qualify the current sample and flag the edge that enters DETECTED.
    always_comb begin
        qual_s      = qualifies(32'(ones_s), 32'(K), bus.mode);
        enter_det_s = 1'b0;
        if (bus.in_val && qual_s) begin
            case (state_r)
                ST_IDLE:     enter_det_s = (HOLD_V == 8'd1);
                ST_ARMING:   enter_det_s = ((hold_cnt_r + 8'd1) == HOLD_V);
                ST_DETECTED: enter_det_s = 1'b0;
                default:     enter_det_s = 1'b0;
            endcase
        end else begin
            enter_det_s = 1'b0;
        end
    end

    // Detector FSM with hold counter, registered outputs and event bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            hold_cnt_r  <= 8'd0;
            out_r       <= 1'b0;
            popcount_r  <= {PW{1'b0}};
            sticky_r    <= 1'b0;
            event_cnt_r <= {CW{1'b0}};
        end else begin
            // Bubbles (in_val=0) leave the streak and all outputs untouched.
            if (bus.in_val) begin
                popcount_r <= ones_s;
                if (!qual_s) begin
                    state_r    <= ST_IDLE;
                    hold_cnt_r <= 8'd0;
                    out_r      <= 1'b0;
                end else begin
                    case (state_r)
                        ST_IDLE: begin
                            if (enter_det_s) begin
                                state_r    <= ST_DETECTED;
                                hold_cnt_r <= 8'd0;
                                out_r      <= 1'b1;
                            end else begin
                                state_r    <= ST_ARMING;
                                hold_cnt_r <= 8'd1;
                                out_r      <= 1'b0;
                            end
                        end
                        ST_ARMING: begin
                            hold_cnt_r <= hold_cnt_r + 8'd1;
                            if (enter_det_s) begin
                                state_r <= ST_DETECTED;
                                out_r   <= 1'b1;
                            end else begin
                                state_r <= ST_ARMING;
                                out_r   <= 1'b0;
                            end
                        end
                        ST_DETECTED: begin
                            state_r <= ST_DETECTED;
                            out_r   <= 1'b1;
                        end
                        default: begin
                            state_r    <= ST_IDLE;
                            hold_cnt_r <= 8'd0;
                            out_r      <= 1'b0;
                        end
                    endcase
                end
            end else begin
                state_r <= state_r;
            end

            // A detect event beats a simultaneous clear: the count restarts at one.
            if (enter_det_s) begin
                sticky_r <= 1'b1;
                if (bus.clear) begin
                    event_cnt_r <= CW'(1'b1);
                end else if (event_cnt_r != CNT_MAX) begin
                    event_cnt_r <= event_cnt_r + CW'(1'b1);
                end else begin
                    event_cnt_r <= event_cnt_r;
                end
            end else if (bus.clear) begin
                sticky_r    <= 1'b0;
                event_cnt_r <= {CW{1'b0}};
            end else begin
                sticky_r <= sticky_r;
            end
        end
    end

    assign bus.out         = out_r;
    assign bus.popcount    = popcount_r;
    assign bus.sticky      = sticky_r;
    assign bus.event_count = event_cnt_r;

endmodule
